// File: rtl/noc_pkg.sv
// Shared NoC packet layout, packet type codes, collector FSM states and the
// ReLU/saturation helper used by the output-feature-map collector.
package noc_pkg;

    localparam int PKT_BITS  = 57;
    localparam int TYPE_LSB  = 55;
    localparam int TYPE_W    = 2;
    localparam int SRC_LSB   = 51;
    localparam int SRC_W     = 4;
    localparam int DST_LSB   = 47;
    localparam int DST_W     = 4;
    // x_dir, x_hop, y_dir and y_hop packed together as one route field
    localparam int ROUTE_LSB = 39;
    localparam int ROUTE_W   = 8;
    localparam int ADDR_LSB  = 13;
    localparam int ADDR_W    = 26;
    localparam int VAL_LSB   = 0;
    localparam int VAL_W     = 13;

    localparam logic [1:0] IFF_SUM   = 2'h3;
    localparam logic [1:0] IFF_OFMAP = 2'h2;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DRAIN   = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic logic [7:0] relu_sat(input logic signed [VAL_W-1:0] v);
        if (v[VAL_W-1])
            return 8'h00;
        else if (|v[VAL_W-2:8])
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    function automatic logic [PKT_BITS-1:0] ofmap_pkt(
        input logic [SRC_W-1:0]  src,
        input logic [DST_W-1:0]  dst,
        input logic [ADDR_W-1:0] addr,
        input logic [7:0]        val
    );
        logic [PKT_BITS-1:0] p;
        p                        = '0;
        p[TYPE_LSB +: TYPE_W]    = IFF_OFMAP;
        p[SRC_LSB +: SRC_W]      = src;
        p[DST_LSB +: DST_W]      = dst;
        p[ROUTE_LSB +: ROUTE_W]  = '0;
        p[ADDR_LSB +: ADDR_W]    = addr;
        p[VAL_LSB +: VAL_W]      = {5'b0, val};
        return p;
    endfunction

endpackage

// File: rtl/ofmap_regfile.sv
// DEPTH x 8 result storage: one synchronous write port, one combinational read port.
module ofmap_regfile #(
    parameter int DEPTH = 9,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ofmap_collector.sv
// Output-feature-map collector: stores ReLU-saturated sums by address and
// drains each completed frame in address order as NoC packets.
module ofmap_collector
    import noc_pkg::*;
#(
    parameter int         DEPTH_O  = 9,
    parameter int         ADDR_O   = 4,
    parameter logic [3:0] OWN_ID   = 4'hD,
    parameter logic [3:0] OUT_DEST = 4'hF,
    parameter int         PKT_W    = 57
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PKT_W-1:0] in_packet,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PKT_W-1:0] out_packet,
    output logic             frame_done,
    output logic             err_type,
    output logic             err_range,
    output logic             err_dup
);

    localparam int                CNT_W    = $clog2(DEPTH_O + 1);
    localparam logic [ADDR_O:0]   DEPTH_V  = (ADDR_O + 1)'(DEPTH_O);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH_O);
    localparam logic [ADDR_O-1:0] LAST_IDX = ADDR_O'(DEPTH_O - 1);

    state_t             r_state;
    logic [DEPTH_O-1:0] r_written;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_O-1:0]  r_rd_ptr;
    logic               r_err_type;
    logic               r_err_range;
    logic               r_err_dup;
    logic [PKT_W-1:0]   r_out_packet;

    logic               w_accept;
    logic               w_type_bad;
    logic               w_range_bad;
    logic               w_dup;
    logic               w_store;
    logic               w_full;
    logic [ADDR_W-1:0]  w_addr;
    logic [ADDR_O-1:0]  w_idx;
    logic [ADDR_O-1:0]  w_rd_addr;
    logic [7:0]         w_wdata;
    logic [7:0]         w_rd_data;
    logic [7:0]         w_next_val;
    logic               w_unused_fields;

    assign in_ready   = (r_state == COLLECT);
    assign out_valid  = (r_state == DRAIN);
    assign frame_done = (r_state == DONE);
    assign out_packet = r_out_packet;
    assign err_type   = r_err_type;
    assign err_range  = r_err_range;
    assign err_dup    = r_err_dup;

    assign w_accept    = in_valid && in_ready;
    assign w_addr      = in_packet[ADDR_LSB +: ADDR_W];
    assign w_idx       = w_addr[ADDR_O-1:0];
    assign w_type_bad  = (in_packet[TYPE_LSB +: TYPE_W] != IFF_SUM);
    assign w_range_bad = (|w_addr[ADDR_W-1:ADDR_O]) || ({1'b0, w_idx} >= DEPTH_V);
    assign w_dup       = r_written[w_idx];
    assign w_store     = w_accept && !w_type_bad && !w_range_bad && !w_dup;
    assign w_full      = w_store && ((r_cnt + CNT_W'(1)) == CNT_FULL);
    assign w_wdata     = relu_sat(in_packet[VAL_LSB +: VAL_W]);

    // Read address always points at the packet to be presented next
    assign w_rd_addr = (r_state == DRAIN && r_rd_ptr != LAST_IDX) ? r_rd_ptr + ADDR_O'(1) : '0;
    // The frame-completing store may target index 0, so forward it past the regfile
    assign w_next_val = (w_store && w_idx == '0) ? w_wdata : w_rd_data;

    assign w_unused_fields = ^{in_packet[SRC_LSB +: SRC_W], in_packet[DST_LSB +: DST_W],
                               in_packet[ROUTE_LSB +: ROUTE_W]};

    ofmap_regfile #(
        .DEPTH (DEPTH_O),
        .AW    (ADDR_O)
    ) u_regfile (
        .clk     (clk),
        .i_we    (w_store),
        .i_waddr (w_idx),
        .i_wdata (w_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= COLLECT;
            r_written    <= '0;
            r_cnt        <= '0;
            r_rd_ptr     <= '0;
            r_err_type   <= 1'b0;
            r_err_range  <= 1'b0;
            r_err_dup    <= 1'b0;
            r_out_packet <= '0;
        end else begin
            if (w_accept) begin
                if (w_type_bad)
                    r_err_type <= 1'b1;
                else if (w_range_bad)
                    r_err_range <= 1'b1;
                else if (w_dup)
                    r_err_dup <= 1'b1;
            end

            case (r_state)
                COLLECT: begin
                    if (w_store) begin
                        r_written[w_idx] <= 1'b1;
                        r_cnt            <= r_cnt + CNT_W'(1);
                        if (w_full) begin
                            r_state      <= DRAIN;
                            r_out_packet <= PKT_W'(ofmap_pkt(OWN_ID, OUT_DEST, '0, w_next_val));
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_rd_ptr <= r_rd_ptr + ADDR_O'(1);
                        if (r_rd_ptr == LAST_IDX) begin
                            r_state      <= DONE;
                            r_out_packet <= '0;
                        end else begin
                            r_out_packet <= PKT_W'(ofmap_pkt(OWN_ID, OUT_DEST,
                                                             ADDR_W'(w_rd_addr), w_next_val));
                        end
                    end
                end
                DONE: begin
                    r_written <= '0;
                    r_cnt     <= '0;
                    r_rd_ptr  <= '0;
                    r_state   <= COLLECT;
                end
                default: r_state <= COLLECT;
            endcase
        end
    end

endmodule

// File: doc/ofmap_collector.md
# ofmap_collector

Clocked output-feature-map collector that sits directly downstream of `partial_sum`. It accepts completed-sum packets and applies ReLU with 8-bit saturation. Results are stored by output address until a full frame of `DEPTH_O` outputs is present. The frame is then drained in address order as NoC packets toward the output node.

## Interface
- `DEPTH_O`, default 9: outputs per frame.
- `ADDR_O`, default 4: index width, ≥ clog2(`DEPTH_O`).
- `OWN_ID`, default 4'hD: value placed in the source field of emitted packets.
- `OUT_DEST`, default 4'hF: value placed in the dest field of emitted packets.
- `PKT_W`, default 57: packet width.

Ports (clock and reset first):
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream packet valid.
- `in_ready` out 1: collector can accept a packet.
- `in_packet` in `PKT_W`: packet from `partial_sum`.
- `out_valid` out 1: drained packet valid.
- `out_ready` in 1: downstream accepts.
- `out_packet` out `PKT_W`: drained packet.
- `frame_done` out 1: one-cycle pulse after the last drain.
- `err_type`, `err_range`, `err_dup` out 1 each: sticky error flags, cleared only by reset.

## Operation
Packet layout:
- `iff_type[56:55]`
- `source[54:51]`
- `dest[50:47]`
- `x_dir[46]`, `x_hop[45:43]`
- `y_dir[42]`, `y_hop[41:39]`
- `psum_addr[38:13]`
- `value[12:0]`, signed two's complement

Accept rule: a transfer occurs on a rising edge with `in_valid && in_ready`.

Checks on each accepted packet, in priority order:
1. `iff_type != 2'h3`: drop the packet, set `err_type`.
2. `idx = psum_addr[ADDR_O-1:0]`; if `idx >= DEPTH_O` or any upper `psum_addr` bit is set: drop, set `err_range`.
3. `written[idx]` already set: drop (the first value is kept), set `err_dup`.
4. Otherwise: `mem[idx] <= relu_sat(value)`, set `written[idx]`, increment `cnt`.

`relu_sat` rule:
- `value < 0` gives 0.
- `value > 255` gives 255.
- Otherwise `value[7:0]`.

State machine:
- **COLLECT** (reset state): `in_ready = 1`. A valid store that makes `cnt == DEPTH_O` moves to DRAIN on the same edge.
- **DRAIN**: `in_ready = 0` and `out_valid = 1`. `out_packet` is formed as follows:
  - `iff_type` = 2'h2, `source` = `OWN_ID`, `dest` = `OUT_DEST`.
  - All hop and direction bits = 0.
  - `psum_addr` = zero-extended `rd_ptr`.
  - `value` = {5'b0, `mem[rd_ptr]`}.
  - On `out_ready`: `rd_ptr` increments. After `rd_ptr == DEPTH_O-1` is accepted, move to DONE.
- **DONE**: `frame_done = 1` and `in_ready = 0` for exactly one cycle. Clear `written`, `cnt` and `rd_ptr`, then return to COLLECT.

## Timing
- Reset values:
  - `in_ready` = 1; `out_valid`, `frame_done` and all `err_*` = 0; `out_packet` = 0.
  - `cnt`, `rd_ptr` and `written` = 0; state = COLLECT.
  - `mem` contents are not reset.
- Throughput: one input per cycle while in COLLECT.
- Latency: with the last valid store at edge t, `out_valid` is high during cycle t+1. The first packet carries index 0.
- Output packet: `out_packet` is registered and stays stable while `out_valid && !out_ready`. `out_valid` never drops without a transfer.
- Drain duration: `DEPTH_O` cycles minimum with `out_ready` held high, followed by 1 DONE cycle.
- Back-pressure: an input presented while `in_ready = 0` is not consumed. Upstream holds it.
- Dropped packets: consume one accept cycle each and do not change `cnt`.
- Reset asserted mid-frame or mid-drain: immediate return to the reset values. Partial frames are discarded.

## Structure
- `noc_pkg` holds:
  - the packet field offsets and widths;
  - `IFF_SUM = 2'h3` and `IFF_OFMAP = 2'h2`;
  - a `state_t` enum {COLLECT, DRAIN, DONE};
  - a `relu_sat` function.
- One sub-module, `ofmap_regfile`: `DEPTH_O` x 8 storage with one write port and one combinational read port. The `written` bitmap stays in the top level.

## Test plan
- **Full ordered frame:** send indices 0..8 with values 5, -3, 300, 0, 255, 256, 17, -4096, 100, `out_ready` held at 1. Required drain, in index order: 5, 0, 255, 0, 255, 255, 17, 0, 100. `frame_done` pulses one cycle after the index-8 packet; `in_ready` is back to 1 the cycle after that.
- **Out-of-order plus back-pressure:** send indices 8 down to 0 with value = idx·10; toggle `out_ready` every cycle. Required: the drain is still in order 0, 10, …, 80, and `out_packet` is unchanged while stalled.
- **Error filtering:** send `iff_type = 2'h0`, then idx 12, then idx 3 twice (values 7, 9). Required: `err_type`, `err_range` and `err_dup` all set; `cnt` = 1; drained idx 3 = 7.
- **Back-to-back frames:** send two full frames with no gap on `in_valid`. Required: the second frame's first packet is held (not consumed) through DRAIN and DONE, then accepted; two `frame_done` pulses total.
- **Reset mid-drain:** assert `rst_n = 0` after 4 drained packets. Required: all outputs return to their reset values asynchronously; a fresh 9-packet frame then drains correctly from index 0.
